// File: rtl/yolo_pkg.sv
// Shared constants and types for the YOLO upsample path.
// Holds the tile geometry used by both the input buffer and the upsample
// stage, the packed word width, and the input-buffer FSM state type.
package yolo_pkg;

  localparam int unsigned DATA_W      = 64;  // 8 channels x 8 bits
  localparam int unsigned TILE_H      = 13;
  localparam int unsigned TILE_W      = 13;
  localparam int unsigned FRAME_WORDS = TILE_H * TILE_W;  // 169
  localparam int unsigned ADDR_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } buf_state_e;

endpackage

// File: rtl/lut_ram_1w1r.sv
// Simple dual-port distributed RAM: synchronous write, asynchronous read.
// Ports:
//   clk            write clock
//   we/waddr/wdata write port, captured on the rising edge
//   raddr/rdata    combinational read port
module lut_ram_1w1r #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned AW    = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/upsample_in_buffer.sv
// Tile buffer in front of the 2x nearest-neighbour upsample stage.
// Loads one 13x13 tile (169 packed words) from AXI-Stream, then presents it
// as a first-word-fall-through read port until every word is consumed.
// Ports:
//   sclk, s_rst_n                 clock, async active-low reset
//   start                         pulse in IDLE arms a tile load
//   s_axis_tdata/tvalid/tready/tlast  input stream
//   buffer_rd_en, buffer_rd_data  FWFT read port toward upsample
//   load_done                     level, tile resident (FULL)
//   frame_done                    pulse, last word consumed
//   err_len                       pulse, tlast not on word FRAME_WORDS-1
module upsample_in_buffer #(
  parameter int unsigned DATA_W      = yolo_pkg::DATA_W,
  parameter int unsigned FRAME_WORDS = yolo_pkg::FRAME_WORDS,
  parameter int unsigned ADDR_W      = yolo_pkg::ADDR_W
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  input  logic              buffer_rd_en,
  output logic [DATA_W-1:0] buffer_rd_data,
  output logic              load_done,
  output logic              frame_done,
  output logic              err_len
);

  import yolo_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_WORDS - 1);

  buf_state_e        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_hs;
  logic              rd_hs;

  // Both handshake strobes are qualified by state so stray inputs are inert.
  assign s_axis_tready = (state == ST_LOAD);
  assign load_done     = (state == ST_FULL);
  assign wr_hs         = s_axis_tready & s_axis_tvalid;
  assign rd_hs         = load_done & buffer_rd_en;

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      frame_done <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      err_len    <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (wr_hs) begin
            if (wr_ptr == LAST_IDX) begin
              // Full tile accepted even if tlast is missing; only flag it.
              state   <= ST_FULL;
              err_len <= ~s_axis_tlast;
            end else if (s_axis_tlast) begin
              state   <= ST_IDLE;
              wr_ptr  <= '0;
              err_len <= 1'b1;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        ST_FULL: begin
          if (rd_hs) begin
            if (rd_ptr == LAST_IDX) begin
              state      <= ST_IDLE;
              wr_ptr     <= '0;
              rd_ptr     <= '0;
              frame_done <= 1'b1;
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  lut_ram_1w1r #(
    .DEPTH (1 << ADDR_W),
    .WIDTH (DATA_W),
    .AW    (ADDR_W)
  ) u_mem (
    .clk   (sclk),
    .we    (wr_hs),
    .waddr (wr_ptr),
    .wdata (s_axis_tdata),
    .raddr (rd_ptr),
    .rdata (buffer_rd_data)
  );

endmodule

// File: tb/tb_upsample_in_buffer.sv
// Directed self-checking bench for upsample_in_buffer.
module tb_upsample_in_buffer;

  logic        sclk = 1'b0;
  logic        s_rst_n;
  logic        start;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic        buffer_rd_en;
  logic [63:0] buffer_rd_data;
  logic        load_done;
  logic        frame_done;
  logic        err_len;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 sclk = ~sclk;

  upsample_in_buffer dut (
    .sclk           (sclk),
    .s_rst_n        (s_rst_n),
    .start          (start),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tlast   (s_axis_tlast),
    .buffer_rd_en   (buffer_rd_en),
    .buffer_rd_data (buffer_rd_data),
    .load_done      (load_done),
    .frame_done     (frame_done),
    .err_len        (err_len)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge sclk);
    #1;
  endtask

  // start pulse, then n words of base+i; tlast on index last_at (-1: none)
  task automatic load_tile(input int n, input int last_at, input int base, input logic exp_err);
    logic err_seen;
    check("tready_before_start", s_axis_tready, 64'd0);
    start = 1'b1;
    tick;
    start = 1'b0;
    check("tready_after_start", s_axis_tready, 64'd1);
    err_seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      s_axis_tdata  = 64'(base + i);
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (i == last_at);
      tick;
      if (i < n - 1 && err_len) err_seen = 1'b1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    check("err_len_during_load", err_seen, 64'd0);
    check("err_len_after_load", err_len, exp_err);
  endtask

  // continuous reads from index first to 168
  task automatic read_range(input int base, input int first);
    for (int i = first; i < 169; i++) begin
      check("rd_data", buffer_rd_data, 64'(base + i));
      buffer_rd_en = 1'b1;
      tick;
      check("frame_done_read", frame_done, 64'(i == 168));
    end
    buffer_rd_en = 1'b0;
    check("load_done_after_frame", load_done, 64'd0);
    tick;
    check("frame_done_single", frame_done, 64'd0);
  endtask

  initial begin
    s_rst_n       = 1'b0;
    start         = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    buffer_rd_en  = 1'b0;
    tick;
    tick;
    check("rst_tready", s_axis_tready, 64'd0);
    check("rst_load_done", load_done, 64'd0);
    check("rst_frame_done", frame_done, 64'd0);
    check("rst_err_len", err_len, 64'd0);
    s_rst_n = 1'b1;
    tick;

    // nominal load and continuous read-back
    load_tile(169, 168, 0, 1'b0);
    check("load_done_nominal", load_done, 64'd1);
    check("tready_full", s_axis_tready, 64'd0);
    check("fwft_word0", buffer_rd_data, 64'd0);
    read_range(0, 0);

    // upsample-style reads with gaps
    load_tile(169, 168, 0, 1'b0);
    check("load_done_gap", load_done, 64'd1);
    for (int g = 0; g < 13; g++) begin
      for (int k = 0; k < 13; k++) begin
        check("gap_rd_data", buffer_rd_data, 64'(g * 13 + k));
        buffer_rd_en = 1'b1;
        tick;
        check("gap_frame_done", frame_done, 64'(g * 13 + k == 168));
      end
      buffer_rd_en = 1'b0;
      if (g < 12) begin
        for (int w = 0; w < 39; w++) begin
          check("gap_stable", buffer_rd_data, 64'(g * 13 + 13));
          tick;
          check("gap_no_done", frame_done, 64'd0);
        end
      end
    end
    check("gap_load_done_low", load_done, 64'd0);
    tick;
    check("gap_done_single", frame_done, 64'd0);

    // early tlast on word 100
    load_tile(101, 100, 300, 1'b1);
    check("early_tready", s_axis_tready, 64'd0);
    check("early_load_done", load_done, 64'd0);
    tick;
    check("early_err_pulse_end", err_len, 64'd0);
    load_tile(169, 168, 1000, 1'b0);
    check("reload_load_done", load_done, 64'd1);
    read_range(1000, 0);

    // missing tlast on word 168
    load_tile(169, -1, 500, 1'b1);
    check("notlast_load_done", load_done, 64'd1);
    s_axis_tdata  = 64'd999;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("full_tready", s_axis_tready, 64'd0);
      tick;
    end
    s_axis_tvalid = 1'b0;
    check("full_no_overwrite", buffer_rd_data, 64'd500);
    check("full_err_once", err_len, 64'd0);
    // start in FULL together with rd_en: only the read acts
    start        = 1'b1;
    buffer_rd_en = 1'b1;
    tick;
    start        = 1'b0;
    buffer_rd_en = 1'b0;
    check("start_ignored_full", load_done, 64'd1);
    read_range(500, 1);

    // reset mid-read
    load_tile(169, 168, 2000, 1'b0);
    for (int i = 0; i < 50; i++) begin
      check("pre_rst_rd", buffer_rd_data, 64'(2000 + i));
      buffer_rd_en = 1'b1;
      tick;
    end
    s_rst_n = 1'b0;
    #1;
    check("mid_rst_tready", s_axis_tready, 64'd0);
    check("mid_rst_load_done", load_done, 64'd0);
    check("mid_rst_frame_done", frame_done, 64'd0);
    check("mid_rst_err_len", err_len, 64'd0);
    check("mid_rst_rd_data", buffer_rd_data, 64'd2000);
    tick;
    s_rst_n       = 1'b1;
    s_axis_tdata  = 64'd777;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      check("stray_tready", s_axis_tready, 64'd0);
      check("stray_load_done", load_done, 64'd0);
      check("stray_rd_data", buffer_rd_data, 64'd2000);
    end
    s_axis_tvalid = 1'b0;
    buffer_rd_en  = 1'b0;
    load_tile(169, 168, 3000, 1'b0);
    check("post_rst_load_done", load_done, 64'd1);
    read_range(3000, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
